// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IFU/LSU memory port arbiter: FSM encoding, requester IDs, request/response records.
// Record widths are the widest the arbiter supports; the top narrows them to its own parameters.
package mem_port_arbiter_pkg;

  localparam int MPA_ADDR_W = 32;
  localparam int MPA_DATA_W = 32;
  localparam int MPA_STRB_W = MPA_DATA_W / 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  typedef struct packed {
    logic                  wr;
    logic [MPA_ADDR_W-1:0] addr;
    logic [MPA_DATA_W-1:0] wdata;
    logic [MPA_STRB_W-1:0] wstrb;
  } req_t;

  typedef struct packed {
    logic [MPA_DATA_W-1:0] rdata;
    logic                  err;
  } resp_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and bus-side signals of the memory port arbiter.
// master: the requesters plus the bus bridge; slave: the arbiter itself.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_resp_rdata;
  logic              ifu_resp_err;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic              lsu_req_wr;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic [DATA_W-1:0] lsu_req_wdata;
  logic [STRB_W-1:0] lsu_req_wstrb;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_resp_rdata;
  logic              lsu_resp_err;

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_req_wr;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [DATA_W-1:0] bus_req_wdata;
  logic [STRB_W-1:0] bus_req_wstrb;
  logic              bus_resp_valid;
  logic [DATA_W-1:0] bus_resp_rdata;

  modport master (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_req_wr, lsu_req_addr, lsu_req_wdata, lsu_req_wstrb,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
    input  bus_req_valid, bus_req_wr, bus_req_addr, bus_req_wdata, bus_req_wstrb,
    output bus_req_ready, bus_resp_valid, bus_resp_rdata
  );

  modport slave (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_req_wr, lsu_req_addr, lsu_req_wdata, lsu_req_wstrb,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
    output bus_req_valid, bus_req_wr, bus_req_addr, bus_req_wdata, bus_req_wstrb,
    input  bus_req_ready, bus_resp_valid, bus_resp_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant, purely combinational (zero latency, no backpressure of its own).
// A lone request wins outright; on a tie the requester that did not win last time is granted.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (&valid) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency bus between IFU and LSU, one transaction at a time; best round trip 3 cycles.
// Requesters see ready only in IDLE; the bus request is held until bus_req_ready, WAIT ends on response or timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = MPA_ADDR_W,
  parameter int DATA_W  = MPA_DATA_W,
  parameter int TIMEOUT = 255
) (
  input logic              clock,
  input logic              reset,
  mem_port_arbiter_if.slave mp
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]       state_q;
  logic             last_grant_q;
  logic             owner_q;
  logic [CNT_W-1:0] cnt_q;
  req_t             req_q;
  resp_t            ifu_resp_q;
  resp_t            lsu_resp_q;
  logic             ifu_resp_vld_q;
  logic             lsu_resp_vld_q;

  logic [1:0] req_vld;
  logic [1:0] grant;
  logic       accept;
  logic       timeout_hit;
  logic       wait_done;
  req_t       new_req;
  resp_t      wait_resp;

  assign req_vld = {mp.lsu_req_valid, mp.ifu_req_valid};

  rr_arbiter2 u_rr_arbiter2 (
    .valid      (req_vld),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Ready is masked by reset so nothing looks accepted while the block is held in reset.
  assign accept           = reset && (state_q == ST_IDLE) && (|req_vld);
  assign mp.ifu_req_ready = accept && grant[REQ_IFU];
  assign mp.lsu_req_ready = accept && grant[REQ_LSU];

  always_comb begin
    new_req = '0;
    if (grant[REQ_LSU]) begin
      new_req.wr    = mp.lsu_req_wr;
      new_req.addr  = MPA_ADDR_W'(mp.lsu_req_addr);
      new_req.wdata = MPA_DATA_W'(mp.lsu_req_wdata);
      new_req.wstrb = MPA_STRB_W'(mp.lsu_req_wstrb);
    end else begin
      new_req.addr  = MPA_ADDR_W'(mp.ifu_req_addr);
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign wait_done   = mp.bus_resp_valid || timeout_hit;

  always_comb begin
    wait_resp = '0;
    if (mp.bus_resp_valid) begin
      wait_resp.rdata = MPA_DATA_W'(mp.bus_resp_rdata);
    end else begin
      wait_resp.err   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= REQ_IFU;
      owner_q        <= REQ_IFU;
      cnt_q          <= '0;
      req_q          <= '0;
      ifu_resp_q     <= '0;
      lsu_resp_q     <= '0;
      ifu_resp_vld_q <= 1'b0;
      lsu_resp_vld_q <= 1'b0;
    end else begin
      ifu_resp_vld_q <= 1'b0;
      lsu_resp_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req_vld) begin
            req_q        <= new_req;
            owner_q      <= grant[REQ_LSU] ? REQ_LSU : REQ_IFU;
            last_grant_q <= grant[REQ_LSU] ? REQ_LSU : REQ_IFU;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mp.bus_req_ready) begin
            cnt_q   <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (wait_done) begin
            state_q <= ST_IDLE;
            if (owner_q == REQ_LSU) begin
              lsu_resp_q     <= wait_resp;
              lsu_resp_vld_q <= 1'b1;
            end else begin
              ifu_resp_q     <= wait_resp;
              ifu_resp_vld_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mp.bus_req_valid  = (state_q == ST_ISSUE);
  assign mp.bus_req_wr     = req_q.wr;
  assign mp.bus_req_addr   = ADDR_W'(req_q.addr);
  assign mp.bus_req_wdata  = DATA_W'(req_q.wdata);
  assign mp.bus_req_wstrb  = STRB_W'(req_q.wstrb);

  assign mp.ifu_resp_valid = ifu_resp_vld_q;
  assign mp.ifu_resp_rdata = DATA_W'(ifu_resp_q.rdata);
  assign mp.ifu_resp_err   = ifu_resp_q.err;
  assign mp.lsu_resp_valid = lsu_resp_vld_q;
  assign mp.lsu_resp_rdata = DATA_W'(lsu_resp_q.rdata);
  assign mp.lsu_resp_err   = lsu_resp_q.err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=8): inputs change 2ns after the rising edge,
// outputs are sampled 4ns after it, well clear of the next edge.
module tb_mem_port_arbiter;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic e_lsu;
  logic p_lsu;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bi ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clock (clock),
    .reset (reset),
    .mp    (bi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bi.ifu_req_valid  = 1'b0;
    bi.ifu_req_addr   = '0;
    bi.lsu_req_valid  = 1'b0;
    bi.lsu_req_wr     = 1'b0;
    bi.lsu_req_addr   = '0;
    bi.lsu_req_wdata  = '0;
    bi.lsu_req_wstrb  = '0;
    bi.bus_req_ready  = 1'b0;
    bi.bus_resp_valid = 1'b0;
    bi.bus_resp_rdata = '0;

    // Reset state
    cyc(); cyc(); #2;
    chk("rst_bus_vld",  bi.bus_req_valid,  0);
    chk("rst_bus_addr", bi.bus_req_addr,   0);
    chk("rst_ifu_vld",  bi.ifu_resp_valid, 0);
    chk("rst_lsu_vld",  bi.lsu_resp_valid, 0);
    chk("rst_ifu_rdy",  bi.ifu_req_ready,  0);
    chk("rst_lsu_err",  bi.lsu_resp_err,   0);
    reset = 1'b1;

    // 1: single IFU read, minimum round trip
    cyc();
    bi.ifu_req_valid = 1'b1; bi.ifu_req_addr = 32'h8000_0000; bi.bus_req_ready = 1'b1;
    #2;
    chk("t1_ifu_rdy", bi.ifu_req_ready, 1);
    chk("t1_lsu_rdy", bi.lsu_req_ready, 0);
    cyc();
    bi.ifu_req_valid = 1'b0;
    #2;
    chk("t1_bus_vld",  bi.bus_req_valid, 1);
    chk("t1_bus_addr", bi.bus_req_addr,  32'h8000_0000);
    chk("t1_bus_wr",   bi.bus_req_wr,    0);
    cyc();
    bi.bus_req_ready = 1'b0; bi.bus_resp_valid = 1'b1; bi.bus_resp_rdata = 32'h0000_0413;
    #2;
    chk("t1_wait_bus_vld", bi.bus_req_valid, 0);
    chk("t1_wait_no_pulse", bi.ifu_resp_valid, 0);
    cyc();
    bi.bus_resp_valid = 1'b0;
    #2;
    chk("t1_ifu_pulse", bi.ifu_resp_valid, 1);
    chk("t1_ifu_rdata", bi.ifu_resp_rdata, 32'h0000_0413);
    chk("t1_ifu_err",   bi.ifu_resp_err,   0);
    chk("t1_lsu_vld",   bi.lsu_resp_valid, 0);
    cyc(); #2;
    chk("t1_pulse_end", bi.ifu_resp_valid, 0);

    // 2: ties right after reset alternate LSU, IFU, LSU, IFU
    do_reset();
    cyc();
    bi.ifu_req_valid = 1'b1; bi.ifu_req_addr = 32'h0000_2000;
    bi.lsu_req_valid = 1'b1; bi.lsu_req_wr = 1'b0; bi.lsu_req_addr = 32'h0000_3000;
    bi.bus_req_ready = 1'b1;
    #2;
    for (int k = 0; k < 4; k++) begin
      e_lsu = (k % 2 == 0);
      chk("t2_lsu_rdy", bi.lsu_req_ready, e_lsu);
      chk("t2_ifu_rdy", bi.ifu_req_ready, !e_lsu);
      if (k > 0) begin
        p_lsu = !e_lsu;
        chk("t2_prev_lsu_vld", bi.lsu_resp_valid, p_lsu);
        chk("t2_prev_ifu_vld", bi.ifu_resp_valid, !p_lsu);
        chk("t2_prev_rdata", p_lsu ? bi.lsu_resp_rdata : bi.ifu_resp_rdata, 32'h1000 + k - 1);
      end
      cyc(); #2;
      chk("t2_bus_vld",  bi.bus_req_valid, 1);
      chk("t2_bus_addr", bi.bus_req_addr, e_lsu ? 32'h0000_3000 : 32'h0000_2000);
      cyc();
      bi.bus_resp_valid = 1'b1; bi.bus_resp_rdata = 32'h1000 + k;
      #2;
      cyc();
      bi.bus_resp_valid = 1'b0;
      if (k == 3) begin
        bi.ifu_req_valid = 1'b0; bi.lsu_req_valid = 1'b0;
      end
      #2;
    end
    chk("t2_last_ifu_vld", bi.ifu_resp_valid, 1);
    chk("t2_last_rdata",   bi.ifu_resp_rdata, 32'h1003);
    chk("t2_last_lsu_vld", bi.lsu_resp_valid, 0);

    // 3: LSU store with bus_req_ready low for 4 ISSUE cycles
    cyc();
    bi.lsu_req_valid = 1'b1; bi.lsu_req_wr = 1'b1; bi.lsu_req_addr = 32'h8000_1004;
    bi.lsu_req_wdata = 32'hdead_beef; bi.lsu_req_wstrb = 4'hF; bi.bus_req_ready = 1'b0;
    #2;
    chk("t3_lsu_rdy", bi.lsu_req_ready, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      bi.lsu_req_valid = 1'b0;
      bi.bus_req_ready = (i == 4);
      #2;
      chk("t3_bus_vld",   bi.bus_req_valid, 1);
      chk("t3_bus_wr",    bi.bus_req_wr,    1);
      chk("t3_bus_addr",  bi.bus_req_addr,  32'h8000_1004);
      chk("t3_bus_wdata", bi.bus_req_wdata, 32'hdead_beef);
      chk("t3_bus_wstrb", bi.bus_req_wstrb, 4'hF);
    end
    cyc();
    bi.bus_req_ready = 1'b0; bi.bus_resp_valid = 1'b1; bi.bus_resp_rdata = 32'h0000_0055;
    #2;
    cyc();
    bi.bus_resp_valid = 1'b0;
    #2;
    chk("t3_ack_vld",   bi.lsu_resp_valid, 1);
    chk("t3_ack_err",   bi.lsu_resp_err,   0);
    chk("t3_ack_rdata", bi.lsu_resp_rdata, 32'h0000_0055);
    chk("t3_ifu_vld",   bi.ifu_resp_valid, 0);

    // 4: timeout after exactly 8 WAIT cycles, late response ignored
    cyc();
    bi.lsu_req_valid = 1'b1; bi.lsu_req_wr = 1'b0; bi.lsu_req_addr = 32'h0000_4000;
    bi.bus_req_ready = 1'b1;
    #2;
    chk("t4_lsu_rdy", bi.lsu_req_ready, 1);
    cyc();
    bi.lsu_req_valid = 1'b0;
    #2;
    chk("t4_bus_vld", bi.bus_req_valid, 1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      bi.bus_req_ready = 1'b0;
      #2;
      chk("t4_wait_no_pulse", bi.lsu_resp_valid, 0);
      chk("t4_wait_bus_vld",  bi.bus_req_valid,  0);
    end
    cyc(); #2;
    chk("t4_to_vld",   bi.lsu_resp_valid, 1);
    chk("t4_to_err",   bi.lsu_resp_err,   1);
    chk("t4_to_rdata", bi.lsu_resp_rdata, 0);
    cyc(); #2;
    chk("t4_to_pulse_end", bi.lsu_resp_valid, 0);
    cyc();
    bi.bus_resp_valid = 1'b1; bi.bus_resp_rdata = 32'h0000_0bad;
    #2;
    cyc();
    bi.bus_resp_valid = 1'b0;
    #2;
    chk("t4_late_lsu", bi.lsu_resp_valid, 0);
    chk("t4_late_ifu", bi.ifu_resp_valid, 0);
    cyc(); #2;
    chk("t4_late_lsu2", bi.lsu_resp_valid, 0);
    chk("t4_err_hold",  bi.lsu_resp_err,   1);

    // 5: reset during WAIT abandons the transaction
    cyc();
    bi.ifu_req_valid = 1'b1; bi.ifu_req_addr = 32'h0000_5000; bi.bus_req_ready = 1'b1;
    #2;
    chk("t5_ifu_rdy", bi.ifu_req_ready, 1);
    cyc();
    bi.ifu_req_valid = 1'b0;
    #2;
    chk("t5_bus_vld", bi.bus_req_valid, 1);
    cyc();
    bi.bus_req_ready = 1'b0; reset = 1'b0;
    #2;
    cyc(); #2;
    chk("t5_bus_vld_rst",  bi.bus_req_valid,  0);
    chk("t5_bus_addr_rst", bi.bus_req_addr,   0);
    chk("t5_ifu_vld_rst",  bi.ifu_resp_valid, 0);
    chk("t5_lsu_vld_rst",  bi.lsu_resp_valid, 0);
    chk("t5_lsu_err_rst",  bi.lsu_resp_err,   0);
    chk("t5_ifu_rd_rst",   bi.ifu_resp_rdata, 0);
    reset = 1'b1;
    cyc(); #2;
    chk("t5_no_resp", bi.ifu_resp_valid, 0);
    cyc();
    bi.ifu_req_valid = 1'b1; bi.ifu_req_addr = 32'h0000_6000; bi.bus_req_ready = 1'b1;
    #2;
    chk("t5_new_rdy", bi.ifu_req_ready, 1);
    cyc();
    bi.ifu_req_valid = 1'b0;
    #2;
    chk("t5_new_addr", bi.bus_req_addr, 32'h0000_6000);
    cyc();
    bi.bus_resp_valid = 1'b1; bi.bus_resp_rdata = 32'h0000_0066;
    #2;
    cyc();
    bi.bus_resp_valid = 1'b0;
    #2;
    chk("t5_new_vld",   bi.ifu_resp_valid, 1);
    chk("t5_new_rdata", bi.ifu_resp_rdata, 32'h0000_0066);

    // 6: back-to-back LSU loads, second accept on the first response pulse
    cyc();
    bi.lsu_req_valid = 1'b1; bi.lsu_req_wr = 1'b0; bi.lsu_req_addr = 32'h0000_7000;
    #2;
    chk("t6_rdy1", bi.lsu_req_ready, 1);
    cyc(); #2;
    cyc();
    bi.bus_resp_valid = 1'b1; bi.bus_resp_rdata = 32'h0000_00a1;
    #2;
    cyc();
    bi.bus_resp_valid = 1'b0;
    #2;
    chk("t6_vld1",   bi.lsu_resp_valid, 1);
    chk("t6_rdata1", bi.lsu_resp_rdata, 32'h0000_00a1);
    chk("t6_rdy2",   bi.lsu_req_ready,  1);
    cyc();
    bi.lsu_req_valid = 1'b0;
    #2;
    chk("t6_gap_vld", bi.lsu_resp_valid, 0);
    chk("t6_bus_vld", bi.bus_req_valid,  1);
    cyc();
    bi.bus_resp_valid = 1'b1; bi.bus_resp_rdata = 32'h0000_00b2;
    #2;
    chk("t6_gap_vld2", bi.lsu_resp_valid, 0);
    cyc();
    bi.bus_resp_valid = 1'b0;
    #2;
    chk("t6_vld2",   bi.lsu_resp_valid, 1);
    chk("t6_rdata2", bi.lsu_resp_rdata, 32'h0000_00b2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
